// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end: the mode codes broadcast
// to every PE and the state encoding of the row feeder sequencer.
package systolic_pkg;

    localparam logic [1:0] MODE_IDLE       = 2'b00;
    localparam logic [1:0] MODE_WS_LOAD    = 2'b01;
    localparam logic [1:0] MODE_OS         = 2'b10;
    localparam logic [1:0] MODE_WS_COMPUTE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } feeder_state_t;

    // Compute code that goes with the dataflow the job was started in.
    function automatic logic [1:0] compute_mode(input logic os);
        return os ? MODE_OS : MODE_WS_COMPUTE;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Advance-gated delay line of DEPTH registers; DEPTH=0 is a plain wire.
// clear and rst both zero the whole line.
module skew_line #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = &{1'b0, clk, rst, advance, clear};
            assign out_data    = in_data;
        end else begin : g_line
            logic [DATA_WIDTH-1:0] stage_reg [DEPTH];

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    stage_reg[0] <= '0;
                end else if (advance) begin
                    stage_reg[0] <= in_data;
                end
            end

            for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
                always_ff @(posedge clk) begin
                    if (rst || clear) begin
                        stage_reg[gi] <= '0;
                    end else if (advance) begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end

            assign out_data = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_row_feeder.sv
// Edge feeder for the WS/OS systolic array: loads weights, skews activations,
// drains the array. Optional stall counter output when FEEDER_STALL_CNT_EN is defined.
module systolic_row_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int MAX_VECS   = 256,
    localparam int VW        = $clog2(MAX_VECS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       cfg_os,
    input  logic [VW-1:0]              cfg_nvec,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [COLS*DATA_WIDTH-1:0] w_data,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] a_data,
    output logic [ROWS*DATA_WIDTH-1:0] row_data,
    output logic [COLS*DATA_WIDTH-1:0] col_weight,
    output logic [1:0]                 mode_ctrl,
    output logic                       weight_clr,
    output logic                       busy,
`ifdef FEEDER_STALL_CNT_EN
    output logic [31:0]                stall_cnt,
`endif
    output logic                       done
);

    localparam int DRAIN_LEN = ROWS - 1 + COLS;
    localparam int BW        = $clog2(ROWS + 1);
    localparam int DCW       = $clog2(DRAIN_LEN + 1);
    localparam logic [BW-1:0]  LAST_BEAT  = BW'(ROWS - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_LEN - 1);
    localparam logic           DRAIN_ONE  = (DRAIN_LEN == 1);

    feeder_state_t  state_reg;
    logic           os_reg;
    logic [VW-1:0]  nvec_reg;
    logic [VW-1:0]  vec_cnt_reg;
    logic [BW-1:0]  beat_cnt_reg;
    logic [DCW-1:0] drain_cnt_reg;
    logic           done_reg;

    logic           w_accept;
    logic           a_accept;
    logic           skew_advance;
    logic           skew_clear;
    logic [VW-1:0]  vec_cnt_inc;
    logic [DCW-1:0] drain_cnt_inc;

    assign w_accept      = (state_reg == ST_LOAD) && w_valid;
    assign a_accept      = (state_reg == ST_STREAM) && a_valid;
    assign skew_advance  = a_accept || (state_reg == ST_DRAIN);
    assign skew_clear    = (state_reg == ST_CLR);
    assign vec_cnt_inc   = vec_cnt_reg + 1'b1;
    assign drain_cnt_inc = drain_cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            os_reg        <= 1'b0;
            nvec_reg      <= '0;
            vec_cnt_reg   <= '0;
            beat_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        os_reg    <= cfg_os;
                        nvec_reg  <= cfg_nvec;
                        state_reg <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    vec_cnt_reg   <= '0;
                    beat_cnt_reg  <= '0;
                    drain_cnt_reg <= '0;
                    if (!os_reg) begin
                        state_reg <= ST_LOAD;
                    end else if (nvec_reg == '0) begin
                        state_reg <= ST_DRAIN;
                        done_reg  <= DRAIN_ONE;
                    end else begin
                        state_reg <= ST_STREAM;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (beat_cnt_reg == LAST_BEAT) begin
                            if (nvec_reg == '0) begin
                                state_reg <= ST_DRAIN;
                                done_reg  <= DRAIN_ONE;
                            end else begin
                                state_reg <= ST_STREAM;
                            end
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (a_accept) begin
                        vec_cnt_reg <= vec_cnt_inc;
                        if (vec_cnt_inc == nvec_reg) begin
                            state_reg <= ST_DRAIN;
                            done_reg  <= DRAIN_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // done is raised during the final drain cycle, so look one ahead.
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_inc;
                        done_reg      <= (drain_cnt_inc == DRAIN_LAST);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mode_ctrl = MODE_IDLE;
        case (state_reg)
            ST_LOAD:   if (w_accept) mode_ctrl = MODE_WS_LOAD;
            ST_STREAM: if (a_accept) mode_ctrl = compute_mode(os_reg);
            ST_DRAIN:  mode_ctrl = compute_mode(os_reg);
            default:   mode_ctrl = MODE_IDLE;
        endcase
    end

    assign col_weight = w_accept ? w_data : '0;
    assign weight_clr = (state_reg == ST_CLR);
    assign w_ready    = (state_reg == ST_LOAD);
    assign a_ready    = (state_reg == ST_STREAM);
    assign busy       = (state_reg != ST_IDLE);
    assign done       = done_reg;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            logic [DATA_WIDTH-1:0] lane_in;
            assign lane_in = a_accept ? a_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

            skew_line #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (gi)
            ) u_skew (
                .clk      (clk),
                .rst      (rst),
                .advance  (skew_advance),
                .clear    (skew_clear),
                .in_data  (lane_in),
                .out_data (row_data[gi*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

`ifdef FEEDER_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic        stall_cycle;

    assign stall_cycle = ((state_reg == ST_LOAD) || (state_reg == ST_STREAM))
                         && (mode_ctrl == MODE_IDLE);

    always_ff @(posedge clk) begin
        if (rst || (state_reg == ST_CLR)) begin
            stall_cnt_reg <= '0;
        end else if (stall_cycle && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule
